node_xmit_encoder: RTL and testbench
====================================

// Module: node_xmit_encoder
// PURPOSE
//  Transmit-side counterpart of the 32-bus receive aggregation. Takes a serial
//  CAN TX bit from the single shared controller and steers it onto one of
//  N_BUS per-node TX lines; all unselected lines are held recessive ('1').
//  A select handshake latches the target bus. The bus is held until the frame
//  ends, an abort, or a watchdog timeout. A recessive guard interval follows.
// PARAMETERS
//  N_BUS          32    number of CAN node buses / TX lines
//  ADDR_W         5     width of bus address, >= clog2(N_BUS)
//  TIMEOUT_CYCLES 4096  max cycles in ARMED+ACTIVE before forced release (>=2)
//  GUARD_CYCLES   8     recessive cycles after release before next select (>=1)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst          in   1       synchronous reset, active-high
//  sel_valid    in   1       request to select bus sel_addr
//  sel_addr     in   ADDR_W  target bus index
//  sel_ready    out  1       high only in IDLE; select accepted when valid&ready
//  abort        in   1       force release of the current selection
//  tx_bit       in   1       serial TX bit from CAN controller
//  tx_busy      in   1       controller frame-in-progress flag
//  can_tx       out  N_BUS   per-bus TX lines, recessive = 1
//  bus_active   out  1       high in ARMED and ACTIVE
//  bus_addr     out  ADDR_W  latched bus index, 0 when idle
//  timeout_err  out  1       1-cycle pulse on watchdog expiry
//  addr_err     out  1       1-cycle pulse on rejected select (addr >= N_BUS)
// BEHAVIOUR
//  Reset: state=IDLE; can_tx = all 1s; bus_active=0; bus_addr=0.
//   timeout_err=0; addr_err=0; cnt=0. sel_ready = (state==IDLE) & ~rst.
//  All outputs are registered except sel_ready.
//  States: IDLE, ARMED, ACTIVE, GUARD.
//  IDLE: sel_valid & sel_addr<N_BUS -> latch bus_addr, cnt<=0, go ARMED.
//   If sel_addr>=N_BUS: addr_err pulses next cycle and state stays IDLE.
//  ARMED: wait for tx_busy=1, then go ACTIVE. can_tx stays all 1s.
//  ACTIVE: stay while tx_busy=1. On tx_busy=0, go GUARD.
//  GUARD: cnt counts GUARD_CYCLES cycles with all lines recessive, then IDLE.
//   bus_addr is cleared to 0 on entry to GUARD.
//  Drive rule: drv = tx_busy & (ARMED|ACTIVE) & ~abort & ~expire.
//   can_tx[i] <= (drv & i==bus_addr) ? tx_bit : 1.
//   Latency: one cycle from tx_bit to can_tx.
//   The bit sampled on the tx_busy rising cycle is driven.
//  Watchdog: cnt increments each cycle in ARMED/ACTIVE.
//   expire = (cnt==TIMEOUT_CYCLES-1).
//  Exit priority in ARMED/ACTIVE: abort > normal end (ACTIVE & ~tx_busy) > expire.
//   All exits go to GUARD with cnt<=0.
//   timeout_err pulses only if the exit is caused by expire.
//  sel_valid outside IDLE is ignored; no queuing.
//   The requester must hold sel_valid until sel_ready.
//  abort in IDLE/GUARD has no effect.
//  tx_busy toggling during GUARD is ignored and no line is driven.
//  rst mid-frame: all lines go recessive on the reset edge and no pulse is emitted.
// TESTING
//  T1 reset: hold rst 3 cycles -> can_tx=32'hFFFFFFFF, bus_active=0, sel_ready=1 after release.
//  T2 frame on bus 17: select 17; tx_busy=1 for 20 cycles with pattern 0101...
//   -> only can_tx[17] follows the pattern 1 cycle late, others=1.
//   -> GUARD lasts 8 cycles, then sel_ready=1.
//  T3 bad address: sel_addr=5'd31 with N_BUS=24 -> addr_err 1-cycle pulse.
//   -> state stays IDLE, can_tx all 1s.
//  T4 timeout: TIMEOUT_CYCLES=16, select 3, never raise tx_busy.
//   -> timeout_err pulses 16 cycles after accept, then GUARD then IDLE.
//  T5 abort mid-frame: bus 0 ACTIVE with tx_bit=0, assert abort.
//   -> can_tx[0]=1 next cycle, no timeout_err.
//  T6 collision: tx_busy falls on the same cycle cnt reaches TIMEOUT_CYCLES-1.
//   -> GUARD entered, timeout_err stays 0.
//   Also: rst asserted in ACTIVE -> all 1s next cycle.

Source files
------------

// File: rtl/node_xmit_encoder_if.sv
// rtl/node_xmit_encoder_if.sv - select handshake and per-bus TX signal bundle
interface node_xmit_encoder_if #(
    parameter int N_BUS  = 32,
    parameter int ADDR_W = 5
);
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_ready;
    logic              abort;
    logic              tx_bit;
    logic              tx_busy;
    logic [N_BUS-1:0]  can_tx;
    logic              bus_active;
    logic [ADDR_W-1:0] bus_addr;
    logic              timeout_err;
    logic              addr_err;

    modport master (
        output sel_valid, sel_addr, abort, tx_bit, tx_busy,
        input  sel_ready, can_tx, bus_active, bus_addr, timeout_err, addr_err
    );

    modport slave (
        input  sel_valid, sel_addr, abort, tx_bit, tx_busy,
        output sel_ready, can_tx, bus_active, bus_addr, timeout_err, addr_err
    );
endinterface

// File: rtl/node_xmit_encoder.sv
// rtl/node_xmit_encoder.sv - steers the shared CAN TX bit onto one of N_BUS lines
module node_xmit_encoder #(
    parameter int N_BUS          = 32,
    parameter int ADDR_W         = 5,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GUARD_CYCLES   = 8
) (
    input  logic             clk,
    input  logic             rst,
    node_xmit_encoder_if.slave bus
);
    // One counter serves both the watchdog and the guard interval.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [ADDR_W:0] N_BUS_L = (ADDR_W+1)'(N_BUS);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, GUARD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic [N_BUS-1:0]   can_tx_q, can_tx_d;
    logic               bus_active_q, bus_active_d;
    logic               timeout_err_q, timeout_err_d;
    logic               addr_err_q, addr_err_d;

    logic               held;
    logic               expire;
    logic               drv;
    logic               addr_ok;

    // Next state, counter, latched address and error pulses.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_addr_d    = bus_addr_q;
        timeout_err_d = 1'b0;
        addr_err_d    = 1'b0;
        held          = (state_q == ARMED) || (state_q == ACTIVE);
        expire        = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        addr_ok       = ({1'b0, bus.sel_addr} < N_BUS_L);
        drv           = bus.tx_busy & held & ~bus.abort & ~expire;

        case (state_q)
            IDLE: begin
                if (bus.sel_valid) begin
                    if (addr_ok) begin
                        bus_addr_d = bus.sel_addr;
                        cnt_d      = '0;
                        state_d    = ARMED;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
            end
            ARMED, ACTIVE: begin
                // abort beats a normal frame end, which beats the watchdog
                if (bus.abort || (state_q == ACTIVE && !bus.tx_busy) || expire) begin
                    timeout_err_d = ~bus.abort & ~(state_q == ACTIVE && !bus.tx_busy);
                    state_d       = GUARD;
                    cnt_d         = '0;
                    bus_addr_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == ARMED && bus.tx_busy) begin
                        state_d = ACTIVE;
                    end
                end
            end
            GUARD: begin
                if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        bus_active_d = (state_d == ARMED) || (state_d == ACTIVE);
    end

    // Only the selected line follows tx_bit; every other line stays recessive.
    always_comb begin
        can_tx_d = '1;
        for (int i = 0; i < N_BUS; i++) begin
            if (drv && bus_addr_q == ADDR_W'(i)) begin
                can_tx_d[i] = bus.tx_bit;
            end
        end
    end

    // State and output registers; reset forces every line recessive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bus_addr_q    <= '0;
            can_tx_q      <= '1;
            bus_active_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_addr_q    <= bus_addr_d;
            can_tx_q      <= can_tx_d;
            bus_active_q  <= bus_active_d;
            timeout_err_q <= timeout_err_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign bus.sel_ready   = (state_q == IDLE) & ~rst;
    assign bus.can_tx      = can_tx_q;
    assign bus.bus_active  = bus_active_q;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.addr_err    = addr_err_q;
endmodule

// File: tb/tb_node_xmit_encoder.sv
// tb/tb_node_xmit_encoder.sv - self-checking bench for node_xmit_encoder
module tb_node_xmit_encoder;
    localparam int NB  = 24;
    localparam int AW  = 5;
    localparam int TO  = 32;
    localparam int GC  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    node_xmit_encoder_if #(.N_BUS(NB), .ADDR_W(AW)) ifc ();

    node_xmit_encoder #(.N_BUS(NB), .ADDR_W(AW), .TIMEOUT_CYCLES(TO), .GUARD_CYCLES(GC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the bus, how long it has been held, guard cycles left.
    int          m_owner = -1;
    int          m_held  = 0;
    int          m_guard = 0;
    bit          m_sending = 0;
    logic [NB-1:0] e_can_tx = '1;
    logic        e_active = 0, e_tout = 0, e_aerr = 0;
    logic [AW-1:0] e_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit expire, ended;
        e_tout   = 0;
        e_aerr   = 0;
        e_can_tx = '1;
        if (rst) begin
            m_owner = -1; m_held = 0; m_guard = 0; m_sending = 0;
        end else if (m_owner >= 0) begin
            expire = (m_held == TO - 1);
            ended  = m_sending && !ifc.tx_busy;
            if (ifc.tx_busy && !ifc.abort && !expire) e_can_tx[m_owner] = ifc.tx_bit;
            if (ifc.abort || ended || expire) begin
                e_tout    = !ifc.abort && !ended;
                m_owner   = -1;
                m_guard   = GC;
                m_sending = 0;
                m_held    = 0;
            end else begin
                m_held++;
                if (ifc.tx_busy) m_sending = 1;
            end
        end else if (m_guard > 0) begin
            m_guard--;
        end else if (ifc.sel_valid) begin
            if (int'(ifc.sel_addr) < NB) begin
                m_owner = int'(ifc.sel_addr);
                m_held  = 0;
            end else begin
                e_aerr = 1;
            end
        end
        e_active = (m_owner >= 0);
        e_addr   = (m_owner >= 0) ? AW'(m_owner) : '0;
    endtask

    // Advance one clock and compare every output against the model.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("can_tx",      32'(ifc.can_tx), 32'(e_can_tx));
        chk("bus_active",  32'(ifc.bus_active), 32'(e_active));
        chk("bus_addr",    32'(ifc.bus_addr), 32'(e_addr));
        chk("timeout_err", 32'(ifc.timeout_err), 32'(e_tout));
        chk("addr_err",    32'(ifc.addr_err), 32'(e_aerr));
        chk("sel_ready",   32'(ifc.sel_ready), 32'(m_owner < 0 && m_guard == 0 && !rst));
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 80 && !ifc.sel_ready; k++) step();
        chk("wait_ready", 32'(ifc.sel_ready), 32'd1);
    endtask

    task automatic select(input logic [AW-1:0] a);
        wait_ready();
        ifc.sel_valid = 1'b1;
        ifc.sel_addr  = a;
        step();
        ifc.sel_valid = 1'b0;
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic          exp_accept;
        logic          exp_aerr;
    } vec_t;

    vec_t vecs[7];
    logic [NB-1:0] exp_vec;
    int cnt;

    initial begin
        vecs[0] = '{5'd0,  1'b1, 1'b0};
        vecs[1] = '{5'd1,  1'b1, 1'b0};
        vecs[2] = '{5'd17, 1'b1, 1'b0};
        vecs[3] = '{5'd23, 1'b1, 1'b0};
        vecs[4] = '{5'd24, 1'b0, 1'b1};
        vecs[5] = '{5'd25, 1'b0, 1'b1};
        vecs[6] = '{5'd31, 1'b0, 1'b1};

        ifc.sel_valid = 0; ifc.sel_addr = '0; ifc.abort = 0;
        ifc.tx_bit = 1;    ifc.tx_busy = 0;

        // T1: reset held three cycles
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("t1_can_tx", 32'(ifc.can_tx), 32'h00FF_FFFF);
        chk("t1_active", 32'(ifc.bus_active), 32'd0);
        rst = 1'b0;
        #1;
        chk("t1_ready", 32'(ifc.sel_ready), 32'd1);

        // Table of selects: in-range accepted, out-of-range flagged
        foreach (vecs[v]) begin
            select(vecs[v].addr);
            chk("tbl_accept", 32'(ifc.bus_active), 32'(vecs[v].exp_accept));
            chk("tbl_aerr",   32'(ifc.addr_err), 32'(vecs[v].exp_aerr));
            chk("tbl_addr",   32'(ifc.bus_addr), vecs[v].exp_accept ? 32'(vecs[v].addr) : 32'd0);
            if (vecs[v].exp_accept) begin
                ifc.abort = 1'b1; step(); ifc.abort = 1'b0;
            end else begin
                step();
                chk("tbl_aerr_pulse", 32'(ifc.addr_err), 32'd0);
                chk("tbl_lines", 32'(ifc.can_tx), 32'h00FF_FFFF);
            end
        end

        // T2: 20-bit 0101 frame on bus 17, then exactly GC guard cycles
        select(5'd17);
        ifc.tx_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ifc.tx_bit = i[0];
            step();
            exp_vec = '1;
            exp_vec[17] = i[0];
            chk("t2_pattern", 32'(ifc.can_tx), 32'(exp_vec));
        end
        ifc.tx_busy = 1'b0; ifc.tx_bit = 1'b1;
        step();
        chk("t2_release", 32'(ifc.bus_active), 32'd0);
        cnt = 0;
        while (!ifc.sel_ready && cnt < 50) begin step(); cnt++; end
        chk("t2_guard_len", 32'(cnt), 32'(GC));

        // T4: watchdog fires TO cycles after accept
        select(5'd3);
        cnt = 0;
        while (!ifc.timeout_err && cnt < 100) begin step(); cnt++; end
        chk("t4_timeout_at", 32'(cnt), 32'(TO));
        step();
        chk("t4_pulse_len", 32'(ifc.timeout_err), 32'd0);

        // T5: abort mid-frame on bus 0
        select(5'd0);
        ifc.tx_busy = 1'b1; ifc.tx_bit = 1'b0;
        step(); step();
        chk("t5_driven", 32'(ifc.can_tx[0]), 32'd0);
        ifc.abort = 1'b1;
        step();
        ifc.abort = 1'b0;
        chk("t5_released", 32'(ifc.can_tx[0]), 32'd1);
        chk("t5_no_tout",  32'(ifc.timeout_err), 32'd0);
        ifc.tx_busy = 1'b0;
        wait_ready();

        // T6: frame end on the watchdog's last cycle counts as normal end
        select(5'd5);
        ifc.tx_busy = 1'b1;
        for (int i = 0; i < TO - 1; i++) step();
        ifc.tx_busy = 1'b0;
        step();
        chk("t6_no_tout", 32'(ifc.timeout_err), 32'd0);
        chk("t6_guard",   32'(ifc.bus_active), 32'd0);

        // Reset during an active frame
        select(5'd9);
        ifc.tx_busy = 1'b1; ifc.tx_bit = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        chk("rst_lines", 32'(ifc.can_tx), 32'h00FF_FFFF);
        chk("rst_tout",  32'(ifc.timeout_err), 32'd0);
        rst = 1'b0; ifc.tx_busy = 1'b0;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            ifc.sel_valid = ($urandom_range(0, 9) < 4);
            ifc.sel_addr  = AW'($urandom_range(0, 31));
            ifc.abort     = ($urandom_range(0, 99) < 2);
            ifc.tx_bit    = 1'($urandom);
            if ($urandom_range(0, 9) == 0) ifc.tx_busy = ~ifc.tx_busy;
            rst = ($urandom_range(0, 999) < 3);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
